// File: rtl/lsu_pkg.sv
// Shared types and helpers for the lsu_mc load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_RESP
  } lsu_state_e;

  localparam int PIO_LEDR = 0;
  localparam int PIO_LEDG = 1;
  localparam int PIO_HEX0 = 2;
  localparam int PIO_HEX1 = 3;
  localparam int PIO_LCD  = 4;

  function automatic logic [3:0] lanes(lsu_size_e size);
    unique case (size)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Lanes of word W touched by an access at byte offset off.
  function automatic logic [3:0] bmask(lsu_size_e size,
                                       logic [1:0] off);
    return lanes(size) << off;
  endfunction

  // Lanes of word W+1 touched when the access spills over.
  function automatic logic [3:0] bmask_hi(lsu_size_e size,
                                          logic [1:0] off);
    return 4'(({4'b0000, lanes(size)} << off) >> 4);
  endfunction

endpackage

// File: rtl/lsu_sram.sv
// Single-port data SRAM: byte-enable write, registered read.
module lsu_sram #(
  parameter int AW = 9
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle LSU fronting data SRAM and PIO registers.
// Define LSU_MISALIGN_EN to split misaligned accesses into two beats.
module lsu_mc
  import lsu_pkg::*;
#(
  parameter int          DMEM_AW   = 9,
  parameter logic [31:0] IO_BASE   = 32'h1000_0000,
  parameter logic [31:0] IO_STRIDE = 32'h0000_1000,
  parameter int          IO_NREG   = 5,
  parameter logic [31:0] SW_ADDR   = 32'h1001_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic [1:0]  i_lsu_size,
  input  logic        i_lsu_signed,
  input  logic        i_lsu_wren,
  output logic        o_rsp_valid,
  output logic [31:0] o_ld_data,
  output logic        o_access_fault,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex [0:7],
  output logic [31:0] o_io_lcd,
  input  logic [31:0] i_io_sw
);

  localparam int IW = (IO_NREG > 1) ? $clog2(IO_NREG) : 1;

  lsu_state_e r_state, w_next;

  logic [DMEM_AW-1:0] r_word;
  logic [1:0]         r_off;
  lsu_size_e          r_size;
  logic               r_signed;
  logic               r_wren;
  logic [31:0]        r_wdata;
  logic               r_fault;
  logic               r_io;
  logic [31:0]        r_io_rdata;
  logic [31:0]        r_pio [0:IO_NREG-1];

  logic               w_accept;
  lsu_size_e          w_sz;
  logic [1:0]         w_off;
  logic               w_mis;
  logic               w_dmem;
  logic [DMEM_AW-1:0] w_word;
  logic [31:0]        w_ioff;
  logic [31:0]        w_ioidx;
  logic               w_io;
  logic               w_sw;
  logic               w_fault;
  logic [31:0]        w_io_rd;

  logic               w_en;
  logic [3:0]         w_we;
  logic [DMEM_AW-1:0] w_maddr;
  logic [31:0]        w_mwdata;
  logic [31:0]        w_rdata;
  logic [31:0]        w_raw;
  logic [31:0]        w_ext;

`ifdef LSU_MISALIGN_EN
  logic               r_split;
  logic [31:0]        r_w0;
  logic               w_split;
  logic [63:0]        w_sd;
  logic [63:0]        w_cat;
`else
  logic [31:0]        w_sd;
`endif

  // Request decode
  assign w_accept = i_req_valid && (r_state == ST_IDLE) && !i_reset;
  assign w_off    = i_lsu_addr[1:0];
  assign w_word   = i_lsu_addr[DMEM_AW+1:2];
  assign w_dmem   = (i_lsu_addr[31:DMEM_AW+2] == '0);
  assign w_ioff   = i_lsu_addr - IO_BASE;
  assign w_ioidx  = w_ioff / IO_STRIDE;
  assign w_io     = ((w_ioff % IO_STRIDE) == '0) && (w_ioidx < IO_NREG);
  assign w_sw     = (i_lsu_addr == SW_ADDR);

  always_comb begin
    w_sz = (i_lsu_size == 2'b11) ? SZ_W : lsu_size_e'(i_lsu_size);
  end

  assign w_mis = ((w_sz == SZ_H) && (w_off == 2'd3)) ||
                 ((w_sz == SZ_W) && (w_off != 2'd0));

`ifdef LSU_MISALIGN_EN
  assign w_split = w_dmem && w_mis;
`endif

  always_comb begin
    w_fault = 1'b1;
    if (w_dmem) begin
`ifdef LSU_MISALIGN_EN
      w_fault = w_mis && (&w_word);
`else
      w_fault = w_mis;
`endif
    end else if (w_io) begin
      w_fault = 1'b0;
    end else if (w_sw) begin
      w_fault = i_lsu_wren;
    end
  end

  always_comb begin
    w_io_rd = '0;
    if (w_sw) w_io_rd = i_io_sw;
    else if (w_io) w_io_rd = r_pio[w_ioidx[IW-1:0]];
  end

  // Request latch and PIO writes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_word     <= '0;
      r_off      <= '0;
      r_size     <= SZ_B;
      r_signed   <= 1'b0;
      r_wren     <= 1'b0;
      r_wdata    <= '0;
      r_fault    <= 1'b0;
      r_io       <= 1'b0;
      r_io_rdata <= '0;
      for (int k = 0; k < IO_NREG; k++) r_pio[k] <= '0;
`ifdef LSU_MISALIGN_EN
      r_split    <= 1'b0;
      r_w0       <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_word     <= w_word;
        r_off      <= w_off;
        r_size     <= w_sz;
        r_signed   <= i_lsu_signed;
        r_wren     <= i_lsu_wren;
        r_wdata    <= i_st_data;
        r_fault    <= w_fault;
        r_io       <= !w_dmem;
        r_io_rdata <= w_io_rd;
`ifdef LSU_MISALIGN_EN
        r_split    <= w_split;
`endif
        if (w_io && i_lsu_wren) r_pio[w_ioidx[IW-1:0]] <= i_st_data;
      end
`ifdef LSU_MISALIGN_EN
      // SRAM still holds word W while BEAT1 reads W+1
      if (r_state == ST_BEAT1) r_w0 <= w_rdata;
`endif
    end
  end

  // FSM
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

`ifdef LSU_MISALIGN_EN
  assign w_sd = {32'b0, r_wdata} << {r_off, 3'b000};
`else
  assign w_sd = r_wdata << {r_off, 3'b000};
`endif

  always_comb begin
    w_next   = r_state;
    w_en     = 1'b0;
    w_we     = 4'b0000;
    w_maddr  = r_word;
    w_mwdata = w_sd[31:0];
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = w_dmem ? ST_BEAT0 : ST_RESP;
      end
      ST_BEAT0: begin
        w_en = 1'b1;
        if (r_wren && !r_fault) w_we = bmask(r_size, r_off);
`ifdef LSU_MISALIGN_EN
        w_next = r_split ? ST_BEAT1 : ST_RESP;
`else
        w_next = ST_RESP;
`endif
      end
`ifdef LSU_MISALIGN_EN
      ST_BEAT1: begin
        w_en     = 1'b1;
        w_maddr  = r_word + 1'b1;
        w_mwdata = w_sd[63:32];
        if (r_wren && !r_fault) w_we = bmask_hi(r_size, r_off);
        w_next   = ST_RESP;
      end
`endif
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (i_reset) begin
      w_next = ST_IDLE;
      w_we   = 4'b0000;
    end
  end

  lsu_sram #(.AW(DMEM_AW)) u_sram (
    .i_clk   (i_clk),
    .i_en    (w_en),
    .i_we    (w_we),
    .i_addr  (w_maddr),
    .i_wdata (w_mwdata),
    .o_rdata (w_rdata)
  );

  // Load alignment and extension
`ifdef LSU_MISALIGN_EN
  assign w_cat = r_split ? {w_rdata, r_w0} : {32'b0, w_rdata};
  assign w_raw = 32'(w_cat >> {r_off, 3'b000});
`else
  assign w_raw = w_rdata >> {r_off, 3'b000};
`endif

  always_comb begin
    w_ext = w_raw;
    unique case (r_size)
      SZ_B: w_ext = r_signed ? {{24{w_raw[7]}}, w_raw[7:0]}
                             : {24'b0, w_raw[7:0]};
      SZ_H: w_ext = r_signed ? {{16{w_raw[15]}}, w_raw[15:0]}
                             : {16'b0, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  assign o_req_ready    = (r_state == ST_IDLE);
  assign o_rsp_valid    = (r_state == ST_RESP);
  assign o_access_fault = o_rsp_valid && r_fault;
  assign o_ld_data      = (o_rsp_valid && !r_fault && !r_wren)
                        ? (r_io ? r_io_rdata : w_ext) : 32'b0;

  assign o_io_ledr = {15'b0, r_pio[PIO_LEDR][16:0]};
  assign o_io_ledg = {15'b0, r_pio[PIO_LEDG][16:0]};
  assign o_io_lcd  = {r_pio[PIO_LCD][31], 20'b0, r_pio[PIO_LCD][10:0]};

  for (genvar k = 0; k < 8; k++) begin : g_hex
    assign o_io_hex[k] = r_pio[PIO_HEX0 + k/4][8*(k%4) +: 7];
  end

endmodule
